// File: rtl/mem_serial_controller_pkg.sv
// Shared types and sizing helpers for the memory serial-port controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      READ = 2'd2,
      RUN  = 2'd3
   } ctrl_state_t;

   // Read needs to count to data_size, so room for data_size+1 values plus margin.
   function automatic int ctrl_cnt_width(input int data_size);
      return $clog2(data_size + 2);
   endfunction

endpackage

// File: rtl/mem_serial_controller_if.sv
// Host-side command bundle: valid/ready frame write, pulsed read and run requests.
interface mem_serial_controller_if #(
   parameter int data_size = 64,
   parameter int gen_width = 16
);

   logic [data_size-1:0] WR_DATA;
   logic                 WR_VALID;
   logic                 WR_READY;
   logic                 RD_REQ;
   logic [data_size-1:0] RD_DATA;
   logic                 RD_VALID;
   logic                 RUN_REQ;
   logic [gen_width-1:0] RUN_GENS;
   logic                 BUSY;

   modport master (
      output WR_DATA, WR_VALID, RD_REQ, RUN_REQ, RUN_GENS,
      input  WR_READY, RD_DATA, RD_VALID, BUSY
   );

   modport slave (
      input  WR_DATA, WR_VALID, RD_REQ, RUN_REQ, RUN_GENS,
      output WR_READY, RD_DATA, RD_VALID, BUSY
   );

endinterface

// File: rtl/mem_serial_controller.sv
// Serial-port sequencer: load (N cycles, MSB first), rotate-read (RD_VALID N+1 after RD_REQ), run G gens.
// WR_READY is low while busy; RD_REQ/RUN_REQ outside IDLE or losing arbitration are dropped.
module mem_serial_controller
   import mem_ctrl_pkg::*;
#(
   parameter int data_size = 64,
   parameter int gen_width = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   mem_serial_controller_if.slave host,
   output logic                   LOAD_MODE,
   output logic                   OUTPUT_MODE,
   output logic                   RUN_MODE,
   output logic                   MEM_SERIAL_IN,
   input  logic                   MEM_SERIAL_OUT
);

   localparam int             CW       = ctrl_cnt_width(data_size);
   localparam logic [CW-1:0]  LAST_BIT = CW'(data_size - 1);
   localparam logic [CW-1:0]  CAP_DONE = CW'(data_size);

   ctrl_state_t          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [data_size-1:0] shift_q, shift_d;
   logic [data_size-1:0] cap_q, cap_d;
   logic [data_size-1:0] rd_data_q, rd_data_d;
   logic [gen_width-1:0] gen_q, gen_d;
   logic                 load_mode_q, load_mode_d;
   logic                 output_mode_q, output_mode_d;
   logic                 run_mode_q, run_mode_d;
   logic                 ser_in_q, ser_in_d;
   logic                 wr_ready_q, wr_ready_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 busy_q, busy_d;
   logic                 wr_go;

   // A write is only taken when WR_READY is actually presented to the host.
   assign wr_go = host.WR_VALID && wr_ready_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         shift_q       <= '0;
         cap_q         <= '0;
         rd_data_q     <= '0;
         gen_q         <= '0;
         load_mode_q   <= 1'b0;
         output_mode_q <= 1'b0;
         run_mode_q    <= 1'b0;
         ser_in_q      <= 1'b0;
         wr_ready_q    <= 1'b0;
         rd_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         cap_q         <= cap_d;
         rd_data_q     <= rd_data_d;
         gen_q         <= gen_d;
         load_mode_q   <= load_mode_d;
         output_mode_q <= output_mode_d;
         run_mode_q    <= run_mode_d;
         ser_in_q      <= ser_in_d;
         wr_ready_q    <= wr_ready_d;
         rd_valid_q    <= rd_valid_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_go)             state_d = LOAD;
            else if (host.RD_REQ)  state_d = READ;
            else if (host.RUN_REQ) state_d = RUN;
         end
         LOAD:    if (cnt_q == LAST_BIT) state_d = IDLE;
         READ:    if (cnt_q == CAP_DONE) state_d = IDLE;
         RUN:     if (gen_q <= gen_width'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      cap_d      = cap_q;
      rd_data_d  = rd_data_q;
      gen_d      = gen_q;
      ser_in_d   = 1'b0;
      rd_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_go) begin
               shift_d  = host.WR_DATA << 1;
               ser_in_d = host.WR_DATA[data_size-1];
               cnt_d    = '0;
            end else if (host.RD_REQ) begin
               cnt_d = '0;
            end else if (host.RUN_REQ) begin
               gen_d = host.RUN_GENS;
            end
         end
         LOAD: begin
            cnt_d = cnt_q + CW'(1);
            if (state_d == LOAD) begin
               ser_in_d = shift_q[data_size-1];
               shift_d  = shift_q << 1;
            end
         end
         READ: begin
            cnt_d = cnt_q + CW'(1);
            // SERIAL_OUT is registered in memory, so the first valid bit lands one edge late.
            if (cnt_q != '0) cap_d = {cap_q[data_size-2:0], MEM_SERIAL_OUT};
            if (cnt_q == CAP_DONE) begin
               rd_data_d  = cap_d;
               rd_valid_d = 1'b1;
            end
         end
         RUN: begin
            gen_d = (gen_q == '0) ? '0 : gen_q - gen_width'(1);
         end
         default: ;
      endcase

      load_mode_d   = (state_d == LOAD);
      // Exactly N rotation edges; the extra READ cycle only captures the last bit.
      output_mode_d = (state_d == READ) && !(state_q == READ && cnt_q >= LAST_BIT);
      run_mode_d    = (state_d == RUN) && (gen_d != '0);
      wr_ready_d    = (state_d == IDLE);
      busy_d        = (state_d != IDLE);
   end

   assign LOAD_MODE     = load_mode_q;
   assign OUTPUT_MODE   = output_mode_q;
   assign RUN_MODE      = run_mode_q;
   assign MEM_SERIAL_IN = ser_in_q;
   assign host.WR_READY = wr_ready_q;
   assign host.RD_DATA  = rd_data_q;
   assign host.RD_VALID = rd_valid_q;
   assign host.BUSY     = busy_q;

endmodule

// File: tb/tb_mem_serial_controller.sv
// Directed bench for mem_serial_controller at data_size 64 and 8, each driving a serial memory model.
module tb_mem_serial_controller;

   logic CLK;
   logic RESET;
   int   n_cmp;
   int   n_bad;

   mem_serial_controller_if #(.data_size(64), .gen_width(16)) if64 ();
   mem_serial_controller_if #(.data_size(8),  .gen_width(16)) if8 ();

   logic lm64, om64, rm64, si64, so64;
   logic lm8, om8, rm8, si8, so8;
   logic [63:0] mem64;
   logic [7:0]  mem8;

   mem_serial_controller #(.data_size(64), .gen_width(16)) dut64 (
      .CLK(CLK), .RESET(RESET), .host(if64),
      .LOAD_MODE(lm64), .OUTPUT_MODE(om64), .RUN_MODE(rm64),
      .MEM_SERIAL_IN(si64), .MEM_SERIAL_OUT(so64)
   );

   mem_serial_controller #(.data_size(8), .gen_width(16)) dut8 (
      .CLK(CLK), .RESET(RESET), .host(if8),
      .LOAD_MODE(lm8), .OUTPUT_MODE(om8), .RUN_MODE(rm8),
      .MEM_SERIAL_IN(si8), .MEM_SERIAL_OUT(so8)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Serial memory: shift-in on LOAD_MODE, rotate with registered SERIAL_OUT on OUTPUT_MODE.
   initial begin
      mem64 = '0; so64 = 1'b0;
      mem8  = '0; so8  = 1'b0;
   end

   always @(posedge CLK) begin
      if (lm64) mem64 <= {mem64[62:0], si64};
      else if (om64) begin
         mem64 <= {mem64[62:0], mem64[63]};
         so64  <= mem64[63];
      end
      if (lm8) mem8 <= {mem8[6:0], si8};
      else if (om8) begin
         mem8 <= {mem8[6:0], mem8[7]};
         so8  <= mem8[7];
      end
   end

   task automatic test_reset;
      n_cmp++; if (lm64 !== 1'b0) begin n_bad++; $display("FAIL rst_lm: got %b want 0", lm64); end
      n_cmp++; if (if64.BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", if64.BUSY); end
      n_cmp++; if (if64.WR_READY !== 1'b0) begin n_bad++; $display("FAIL rst_rdy: got %b want 0", if64.WR_READY); end
      n_cmp++; if (if64.RD_DATA !== 64'h0) begin n_bad++; $display("FAIL rst_rddata: got %h want 0", if64.RD_DATA); end
      RESET = 1'b0;
      @(negedge CLK);
      n_cmp++; if (if64.WR_READY !== 1'b1) begin n_bad++; $display("FAIL rst_rdy_after: got %b want 1", if64.WR_READY); end
      if64.WR_DATA  = 64'hFFFF_0000_AAAA_5555;
      if64.WR_VALID = 1'b1;
      @(negedge CLK);
      if64.WR_VALID = 1'b0;
      repeat (9) @(negedge CLK);
      n_cmp++; if (lm64 !== 1'b1) begin n_bad++; $display("FAIL rst_midload: got %b want 1", lm64); end
      #2 RESET = 1'b1;
      #1;
      n_cmp++; if (lm64 !== 1'b0) begin n_bad++; $display("FAIL rst_async_lm: got %b want 0", lm64); end
      n_cmp++; if (if64.BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", if64.BUSY); end
      n_cmp++; if (si64 !== 1'b0) begin n_bad++; $display("FAIL rst_async_si: got %b want 0", si64); end
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      n_cmp++; if (if64.WR_READY !== 1'b1) begin n_bad++; $display("FAIL rst_rdy_release: got %b want 1", if64.WR_READY); end
      n_cmp++; if (if64.RD_DATA !== 64'h0) begin n_bad++; $display("FAIL rst_rddata2: got %h want 0", if64.RD_DATA); end
   endtask

   task automatic test_load(input logic [63:0] val);
      int lm_cnt;
      int rdy_hi;
      lm_cnt = 0; rdy_hi = 0;
      if64.WR_DATA  = val;
      if64.WR_VALID = 1'b1;
      @(negedge CLK);
      if64.WR_VALID = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (lm64 !== 1'b1) break;
         lm_cnt++;
         if (if64.WR_READY !== 1'b0) rdy_hi++;
         @(negedge CLK);
      end
      n_cmp++; if (lm_cnt != 64) begin n_bad++; $display("FAIL load_len: got %0d want 64", lm_cnt); end
      n_cmp++; if (rdy_hi != 0) begin n_bad++; $display("FAIL load_rdy_low: got %0d ready cycles want 0", rdy_hi); end
      n_cmp++; if (mem64 !== val) begin n_bad++; $display("FAIL load_mem: got %h want %h", mem64, val); end
      n_cmp++; if (if64.WR_READY !== 1'b1) begin n_bad++; $display("FAIL load_rdy_after: got %b want 1", if64.WR_READY); end
   endtask

   task automatic test_readback(input logic [63:0] val);
      int om_cnt;
      int rv_cnt;
      int rv_at;
      om_cnt = 0; rv_cnt = 0; rv_at = -1;
      @(negedge CLK);
      if64.RD_REQ = 1'b1;
      @(negedge CLK);
      if64.RD_REQ = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (om64 === 1'b1) om_cnt++;
         if (if64.RD_VALID === 1'b1) begin
            rv_cnt++;
            if (rv_at < 0) rv_at = k;
         end
         @(negedge CLK);
      end
      n_cmp++; if (om_cnt != 64) begin n_bad++; $display("FAIL rd_om_len: got %0d want 64", om_cnt); end
      n_cmp++; if (rv_at != 65) begin n_bad++; $display("FAIL rd_latency: got %0d want 65", rv_at); end
      n_cmp++; if (rv_cnt != 1) begin n_bad++; $display("FAIL rd_pulse: got %0d want 1", rv_cnt); end
      n_cmp++; if (if64.RD_DATA !== val) begin n_bad++; $display("FAIL rd_data: got %h want %h", if64.RD_DATA, val); end
      n_cmp++; if (mem64 !== val) begin n_bad++; $display("FAIL rd_mem_kept: got %h want %h", mem64, val); end
   endtask

   task automatic test_run(input logic [15:0] gens, input int exp_run, input int exp_busy);
      int rm_cnt;
      int busy_cnt;
      rm_cnt = 0; busy_cnt = 0;
      @(negedge CLK);
      if64.RUN_GENS = gens;
      if64.RUN_REQ  = 1'b1;
      @(negedge CLK);
      if64.RUN_REQ  = 1'b0;
      if64.RUN_GENS = 16'hFFFF;
      for (int k = 0; k < 12; k++) begin
         if (rm64 === 1'b1) rm_cnt++;
         if (if64.BUSY === 1'b1) busy_cnt++;
         @(negedge CLK);
      end
      n_cmp++; if (rm_cnt != exp_run) begin n_bad++; $display("FAIL run_len_g%0d: got %0d want %0d", gens, rm_cnt, exp_run); end
      n_cmp++; if (busy_cnt != exp_busy) begin n_bad++; $display("FAIL run_busy_g%0d: got %0d want %0d", gens, busy_cnt, exp_busy); end
   endtask

   task automatic test_arbitration;
      int lm_cnt;
      int om_cnt;
      int rm_cnt;
      int excl;
      lm_cnt = 0; om_cnt = 0; rm_cnt = 0; excl = 0;
      @(negedge CLK);
      if64.WR_DATA  = 64'h0123_4567_89AB_CDEF;
      if64.WR_VALID = 1'b1;
      if64.RD_REQ   = 1'b1;
      if64.RUN_REQ  = 1'b1;
      if64.RUN_GENS = 16'd5;
      @(negedge CLK);
      if64.WR_VALID = 1'b0;
      if64.RD_REQ   = 1'b0;
      if64.RUN_REQ  = 1'b0;
      for (int k = 0; k < 90; k++) begin
         if (k == 20) if64.RD_REQ = 1'b1;
         if (k == 21) if64.RD_REQ = 1'b0;
         if (lm64 === 1'b1) lm_cnt++;
         if (om64 === 1'b1) om_cnt++;
         if (rm64 === 1'b1) rm_cnt++;
         if ((32'(lm64) + 32'(om64) + 32'(rm64)) > 1) excl++;
         @(negedge CLK);
      end
      n_cmp++; if (lm_cnt != 64) begin n_bad++; $display("FAIL arb_load: got %0d want 64", lm_cnt); end
      n_cmp++; if (om_cnt != 0) begin n_bad++; $display("FAIL arb_read_dropped: got %0d want 0", om_cnt); end
      n_cmp++; if (rm_cnt != 0) begin n_bad++; $display("FAIL arb_run_dropped: got %0d want 0", rm_cnt); end
      n_cmp++; if (excl != 0) begin n_bad++; $display("FAIL arb_exclusive: got %0d overlaps want 0", excl); end
      n_cmp++; if (mem64 !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL arb_mem: got %h want 0123456789abcdef", mem64); end
   endtask

   task automatic test_small;
      logic [7:0] seq;
      int lm_cnt;
      int rv_at;
      seq = '0; lm_cnt = 0; rv_at = -1;
      @(negedge CLK);
      if8.WR_DATA  = 8'hA5;
      if8.WR_VALID = 1'b1;
      @(negedge CLK);
      if8.WR_VALID = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (lm8 !== 1'b1) break;
         lm_cnt++;
         seq = {seq[6:0], si8};
         @(negedge CLK);
      end
      n_cmp++; if (lm_cnt != 8) begin n_bad++; $display("FAIL w8_len: got %0d want 8", lm_cnt); end
      n_cmp++; if (seq !== 8'hA5) begin n_bad++; $display("FAIL w8_serial_seq: got %b want 10100101", seq); end
      n_cmp++; if (mem8 !== 8'hA5) begin n_bad++; $display("FAIL w8_mem: got %h want a5", mem8); end
      @(negedge CLK);
      if8.RD_REQ = 1'b1;
      @(negedge CLK);
      if8.RD_REQ = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (if8.RD_VALID === 1'b1 && rv_at < 0) rv_at = k;
         @(negedge CLK);
      end
      n_cmp++; if (rv_at != 9) begin n_bad++; $display("FAIL w8_rd_latency: got %0d want 9", rv_at); end
      n_cmp++; if (if8.RD_DATA !== 8'hA5) begin n_bad++; $display("FAIL w8_rd_data: got %h want a5", if8.RD_DATA); end
      n_cmp++; if (mem8 !== 8'hA5) begin n_bad++; $display("FAIL w8_mem_kept: got %h want a5", mem8); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      RESET = 1'b1;
      if64.WR_DATA = '0; if64.WR_VALID = 1'b0; if64.RD_REQ = 1'b0;
      if64.RUN_REQ = 1'b0; if64.RUN_GENS = '0;
      if8.WR_DATA = '0; if8.WR_VALID = 1'b0; if8.RD_REQ = 1'b0;
      if8.RUN_REQ = 1'b0; if8.RUN_GENS = '0;
      repeat (2) @(negedge CLK);

      test_reset;
      test_load(64'hDEAD_BEEF_0123_4567);
      test_readback(64'hDEAD_BEEF_0123_4567);
      test_readback(64'hDEAD_BEEF_0123_4567);
      test_run(16'd3, 3, 3);
      test_run(16'd0, 0, 1);
      test_arbitration;
      test_small;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_serial_controller.md
Name: mem_serial_controller

Overview:
Host-side sequencer for the system memory's serial port. It accepts a parallel frame and shifts it into system memory over the serial link. It reads a frame back out of system memory, with exactly one full rotation so memory content is preserved. It also issues a programmed number of RUN_MODE cycles, which are grid generations. It is the only driver of the memory's LOAD_MODE, OUTPUT_MODE, RUN_MODE and SERIAL_IN.

Parameters:
data_size, 64, frame width in bits; must match the system memory width
gen_width, 16, width of the generation count

Ports:
CLK  input  1  system clock
RESET  input  1  reset, asynchronous, active-high
WR_DATA  input  data_size  frame to load into memory
WR_VALID  input  1  write request; held until accepted
WR_READY  output  1  high only in IDLE; a transfer occurs on WR_VALID&&WR_READY
RD_REQ  input  1  single-cycle read request
RD_DATA  output  data_size  last frame read from memory
RD_VALID  output  1  one-cycle pulse when RD_DATA has been updated
RUN_REQ  input  1  single-cycle run request
RUN_GENS  input  gen_width  generation count, sampled with RUN_REQ
BUSY  output  1  high in any state other than IDLE
LOAD_MODE  output  1  to memory LOAD_MODE
OUTPUT_MODE  output  1  to memory OUTPUT_MODE
RUN_MODE  output  1  to memory RUN_MODE
MEM_SERIAL_IN  output  1  to memory SERIAL_IN
MEM_SERIAL_OUT  input  1  from memory SERIAL_OUT (registered inside memory)

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE. RD_DATA and the internal shift and capture registers reset to 0.
- States:
  - IDLE, LOAD, READ, RUN.
  - Commands are sampled only in IDLE.
  - Priority in IDLE is write > read > run. A losing or out-of-IDLE RD_REQ or RUN_REQ is dropped, not queued.
- Counter width is $clog2(data_size+2).
- IDLE→LOAD, on handshake at edge e0:
  - WR_DATA is latched into the shift register.
  - LOAD_MODE=1 for edges e1..eN, where N=data_size. MEM_SERIAL_IN carries the frame MSB first, bit N-1 sampled by memory at e1 and bit 0 at eN.
  - After eN, memory holds WR_DATA exactly.
  - LOAD_MODE drops and the state returns to IDLE; WR_READY is high again after eN.
- IDLE→READ, on RD_REQ at e0:
  - OUTPUT_MODE=1 for exactly N memory edges, e1..eN. This gives one full rotation and leaves memory unchanged.
  - Memory presents bit N-1 after e1 and bit 0 after eN.
  - The controller samples MEM_SERIAL_IN's counterpart MEM_SERIAL_OUT at e2..e(N+1) and shifts each bit into the capture LSB.
  - At e(N+1), RD_DATA is loaded with the completed frame and RD_VALID=1 for one cycle. The state returns to IDLE.
  - Read latency from RD_REQ to RD_VALID is N+1 cycles.
  - RD_DATA holds its value until the next read completes.
- IDLE→RUN, on RUN_REQ:
  - RUN_GENS is latched into a down-counter.
  - If it is 0, the state returns to IDLE next cycle and RUN_MODE never asserts.
  - Otherwise RUN_MODE=1 for exactly RUN_GENS consecutive cycles, then IDLE.
- Exclusivity: at most one of LOAD_MODE, OUTPUT_MODE and RUN_MODE is high in any cycle.
- MEM_SERIAL_IN is 0 outside LOAD.
- Reset mid-operation: immediate return to IDLE with all mode outputs at 0. A partially loaded frame in memory is not repaired.
- Back-to-back commands: the next command can be accepted on the first IDLE cycle after completion.

Decomposition:
- Package mem_ctrl_pkg holds:
  - typedef enum ctrl_state_t {IDLE, LOAD, READ, RUN};
  - the counter width function/constant.
- Single module. The PISO/SIPO shift registers are inline; no sub-module is warranted.

Test Plan:
- Reset:
  - Stimulus: assert RESET while in LOAD at bit 10 of 64.
  - Response: LOAD_MODE=0 and BUSY=0 immediately, WR_READY=1 after RESET falls, RD_DATA=0.
- Load:
  - Stimulus: WR_DATA=64'hDEADBEEF01234567 handshake.
  - Response: LOAD_MODE high for exactly 64 cycles, WR_READY low throughout, memory output = 64'hDEADBEEF01234567 afterwards.
- Readback:
  - Stimulus: RD_REQ after the load.
  - Response: OUTPUT_MODE high for exactly 64 cycles, RD_VALID pulse 65 cycles after RD_REQ, RD_DATA=64'hDEADBEEF01234567, memory still 64'hDEADBEEF01234567.
  - Stimulus: a second RD_REQ.
  - Response: identical RD_DATA.
- Run:
  - Stimulus: RUN_GENS=3 with RUN_REQ.
  - Response: RUN_MODE high for exactly 3 cycles.
  - Stimulus: RUN_GENS=0.
  - Response: no RUN_MODE, BUSY for 1 cycle.
- Arbitration:
  - Stimulus: WR_VALID, RD_REQ and RUN_REQ all in the same IDLE cycle.
  - Response: the write is taken; the read and run are dropped (no OUTPUT_MODE or RUN_MODE afterwards).
  - Stimulus: RD_REQ during LOAD.
  - Response: ignored.
- Small width:
  - Stimulus: data_size=8, load 8'hA5 then read.
  - Response: MEM_SERIAL_IN sequence 1,0,1,0,0,1,0,1; RD_DATA=8'hA5 after 9 cycles.
